// File: rtl/hwpe_stream_packer_if.sv
// Bundle of the packer's control plane, narrow input stream and wide output stream.
//   slave  : used by the packer (control and input stream in, output stream out)
//   master : used by whoever drives the packer (engine plus store stage)
interface hwpe_stream_packer_if #(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = 128,
    parameter int unsigned LEN_WIDTH = 16
);
    logic                   ctrl_start_i;
    logic [LEN_WIDTH-1:0]   ctrl_len_i;
    logic                   ready_start_o;
    logic                   done_o;

    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [IN_WIDTH-1:0]    in_data_i;
    logic [IN_WIDTH/8-1:0]  in_strb_i;

    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [OUT_WIDTH-1:0]   out_data_o;
    logic [OUT_WIDTH/8-1:0] out_strb_o;

    modport slave (
        input  ctrl_start_i, ctrl_len_i, in_valid_i, in_data_i, in_strb_i, out_ready_i,
        output ready_start_o, done_o, in_ready_o, out_valid_o, out_data_o, out_strb_o
    );

    modport master (
        output ctrl_start_i, ctrl_len_i, in_valid_i, in_data_i, in_strb_i, out_ready_i,
        input  ready_start_o, done_o, in_ready_o, out_valid_o, out_data_o, out_strb_o
    );
endinterface

// File: rtl/hwpe_stream_packer.sv
// Packs a counted burst of IN_WIDTH-bit stream beats into OUT_WIDTH-bit words
// with per-byte strobes, for the TCDM store stage.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   clear_i        : synchronous soft clear, same effect as rst_i
//   bus (slave)    : ctrl_start/len, ready_start, done; in_* narrow stream; out_* wide stream
module hwpe_stream_packer #(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = 128,
    parameter int unsigned LEN_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    hwpe_stream_packer_if.slave  bus
);
    localparam int unsigned RATIO     = OUT_WIDTH / IN_WIDTH;
    localparam int unsigned IN_BYTES  = IN_WIDTH / 8;
    localparam int unsigned OUT_BYTES = OUT_WIDTH / 8;
    localparam int unsigned IDX_W     = $clog2(RATIO);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [OUT_WIDTH-1:0] acc_data_q, acc_data_d;
    logic [OUT_BYTES-1:0] acc_strb_q, acc_strb_d;
    logic                 out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [OUT_BYTES-1:0] out_strb_q, out_strb_d;
    logic                 done_q, done_d;

    logic                 last_beat_c;
    logic                 completing_c;
    logic                 in_ready_c;
    logic                 accept_c;
    logic [OUT_WIDTH-1:0] merged_data_c;
    logic [OUT_BYTES-1:0] merged_strb_c;

    // A completing beat may only be taken if the output register can accept the new word.
    assign last_beat_c  = (cnt_q == len_q - LEN_WIDTH'(1));
    assign completing_c = (idx_q == IDX_W'(RATIO - 1)) || last_beat_c;
    assign in_ready_c   = (state_q == ST_FILL) && !(completing_c && out_valid_q && !bus.out_ready_i);
    assign accept_c     = bus.in_valid_i && in_ready_c;

    // Accumulator with the current beat dropped into lane idx.
    always_comb begin
        merged_data_c = acc_data_q;
        merged_strb_c = acc_strb_q;
        for (int k = 0; k < RATIO; k++) begin
            if (idx_q == IDX_W'(k)) begin
                merged_data_c[k*IN_WIDTH +: IN_WIDTH] = bus.in_data_i;
                merged_strb_c[k*IN_BYTES +: IN_BYTES] = bus.in_strb_i;
            end
        end
    end

    // Next-state and datapath.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        acc_data_d  = acc_data_q;
        acc_strb_d  = acc_strb_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_strb_d  = out_strb_q;
        done_d      = 1'b0;

        // Handshake frees the output register; a same-cycle completing accept reloads it below.
        if (out_valid_q && bus.out_ready_i) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.ctrl_start_i) begin
                    len_d   = bus.ctrl_len_i;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = (bus.ctrl_len_i == '0) ? ST_DRAIN : ST_FILL;
                end
            end
            ST_FILL: begin
                if (accept_c) begin
                    cnt_d = cnt_q + LEN_WIDTH'(1);
                    if (completing_c) begin
                        out_valid_d = 1'b1;
                        out_data_d  = merged_data_c;
                        out_strb_d  = merged_strb_c;
                        acc_data_d  = '0;
                        acc_strb_d  = '0;
                        idx_d       = '0;
                        if (last_beat_c) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        acc_data_d = merged_data_c;
                        acc_strb_d = merged_strb_c;
                        idx_d      = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (!out_valid_q || bus.out_ready_i) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; clear_i behaves exactly like reset.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            acc_data_q  <= '0;
            acc_strb_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            acc_data_q  <= acc_data_d;
            acc_strb_q  <= acc_strb_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_strb_q  <= out_strb_d;
            done_q      <= done_d;
        end
    end

    assign bus.ready_start_o = (state_q == ST_IDLE);
    assign bus.done_o        = done_q;
    assign bus.in_ready_o    = in_ready_c;
    assign bus.out_valid_o   = out_valid_q;
    assign bus.out_data_o    = out_data_q;
    assign bus.out_strb_o    = out_strb_q;
endmodule

// File: tb/tb_hwpe_stream_packer.sv
// Directed bench for hwpe_stream_packer with IN_WIDTH=32, OUT_WIDTH=128 (RATIO=4).
module tb_hwpe_stream_packer;
    localparam int unsigned IW = 32;
    localparam int unsigned OW = 128;
    localparam int unsigned LW = 16;

    logic clk = 1'b0;
    logic rst;
    logic clear;
    always #5 clk = ~clk;

    hwpe_stream_packer_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LEN_WIDTH(LW)) bus ();

    hwpe_stream_packer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LEN_WIDTH(LW)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clear),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Cycle counter and passive monitor of handshakes / pulses.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [OW-1:0]   wq_data[$];
    logic [OW/8-1:0] wq_strb[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int hs_cyc   = 0;
    int ir_cnt   = 0;
    int ov_cnt   = 0;

    always @(negedge clk) begin
        if (!rst && !clear) begin
            if (bus.out_valid_o && bus.out_ready_i) begin
                wq_data.push_back(bus.out_data_o);
                wq_strb.push_back(bus.out_strb_o);
                hs_cyc <= cyc;
            end
            if (bus.done_o) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (bus.in_ready_o)  ir_cnt <= ir_cnt + 1;
            if (bus.out_valid_o) ov_cnt <= ov_cnt + 1;
        end
    end

    function automatic logic [OW-1:0] word_d(input int i);
        return (i < wq_data.size()) ? wq_data[i] : '0;
    endfunction

    function automatic logic [OW/8-1:0] word_s(input int i);
        return (i < wq_strb.size()) ? wq_strb[i] : '0;
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic start_burst(input logic [LW-1:0] len, output int st_cyc);
        bus.ctrl_start_i = 1'b1;
        bus.ctrl_len_i   = len;
        st_cyc           = cyc;
        @(posedge clk); #1;
        bus.ctrl_start_i = 1'b0;
    endtask

    // Offers n beats back to back; beat sp_idx carries sp_strb, others full strobes.
    task automatic drive_beats(input int n, input logic [IW-1:0] base, input int sp_idx,
                               input logic [IW/8-1:0] sp_strb, output int stalls, output int first_stall);
        int g;
        stalls      = 0;
        first_stall = -1;
        for (int i = 0; i < n; i++) begin
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = base + IW'(i);
            bus.in_strb_i  = (i == sp_idx) ? sp_strb : '1;
            g = 0;
            @(negedge clk);
            while (!bus.in_ready_o && g < 100) begin
                if (first_stall < 0) first_stall = i;
                stalls++;
                g++;
                @(negedge clk);
            end
            @(posedge clk); #1;
        end
        bus.in_valid_i = 1'b0;
        bus.in_strb_i  = '0;
    endtask

    task automatic wait_done(input string name);
        int d0 = done_cnt;
        int g  = 0;
        while (done_cnt == d0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        n_checks++;
        if (done_cnt == d0) begin
            n_fail++;
            $display("FAIL %s done timeout: no done_o within %0d cycles", name, g);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_cycles(3);
        rst = 1'b0;
        n_checks++;
        if (bus.ready_start_o !== 1'b1) begin n_fail++; $display("FAIL reset ready_start: got %b want 1", bus.ready_start_o); end
        n_checks++;
        if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid_o); end
        n_checks++;
        if (bus.in_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset in_ready: got %b want 0", bus.in_ready_o); end
        n_checks++;
        if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", bus.done_o); end
        n_checks++;
        if (bus.out_data_o !== '0 || bus.out_strb_o !== '0) begin
            n_fail++; $display("FAIL reset out_data/strb: got %h/%h want 0/0", bus.out_data_o, bus.out_strb_o);
        end
    endtask

    task automatic test_full_burst();
        int st, stalls, fs;
        int wb = wq_data.size();
        int d0 = done_cnt;
        int i0 = ir_cnt;
        start_burst(16'd8, st);
        drive_beats(8, 32'h0, -1, 4'h0, stalls, fs);
        wait_done("full");
        idle_cycles(3);
        n_checks++;
        if (wq_data.size() - wb != 2) begin n_fail++; $display("FAIL full word count: got %0d want 2", wq_data.size() - wb); end
        n_checks++;
        if (word_d(wb) !== {32'h3, 32'h2, 32'h1, 32'h0} || word_s(wb) !== 16'hFFFF) begin
            n_fail++; $display("FAIL full word0: got %h/%h want 00000003000000020000000100000000/ffff", word_d(wb), word_s(wb));
        end
        n_checks++;
        if (word_d(wb+1) !== {32'h7, 32'h6, 32'h5, 32'h4} || word_s(wb+1) !== 16'hFFFF) begin
            n_fail++; $display("FAIL full word1: got %h/%h want 00000007000000060000000500000004/ffff", word_d(wb+1), word_s(wb+1));
        end
        n_checks++;
        if (stalls != 0 || ir_cnt - i0 != 8) begin
            n_fail++; $display("FAIL full in_ready: stalls %0d high cycles %0d want 0 and 8", stalls, ir_cnt - i0);
        end
        n_checks++;
        if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL full done count: got %0d want 1", done_cnt - d0); end
        n_checks++;
        if (done_cyc != hs_cyc + 1) begin n_fail++; $display("FAIL full done timing: done cycle %0d want %0d", done_cyc, hs_cyc + 1); end
    endtask

    task automatic test_partial();
        int st, stalls, fs;
        int wb = wq_data.size();
        int d0 = done_cnt;
        start_burst(16'd6, st);
        drive_beats(6, 32'h0, -1, 4'h0, stalls, fs);
        wait_done("partial");
        idle_cycles(2);
        n_checks++;
        if (wq_data.size() - wb != 2) begin n_fail++; $display("FAIL partial word count: got %0d want 2", wq_data.size() - wb); end
        n_checks++;
        if (word_d(wb) !== {32'h3, 32'h2, 32'h1, 32'h0} || word_s(wb) !== 16'hFFFF) begin
            n_fail++; $display("FAIL partial word0: got %h/%h", word_d(wb), word_s(wb));
        end
        n_checks++;
        if (word_d(wb+1) !== {32'h0, 32'h0, 32'h5, 32'h4} || word_s(wb+1) !== 16'h00FF) begin
            n_fail++; $display("FAIL partial word1: got %h/%h want 00000000000000000000000500000004/00ff", word_d(wb+1), word_s(wb+1));
        end
        n_checks++;
        if (done_cnt - d0 != 1 || bus.ready_start_o !== 1'b1) begin
            n_fail++; $display("FAIL partial done/ready_start: got %0d/%b want 1/1", done_cnt - d0, bus.ready_start_o);
        end
    endtask

    task automatic test_backpressure();
        int st, stalls, fs, g, held_bad;
        int wb = wq_data.size();
        held_bad = 0;
        start_burst(16'd8, st);
        fork
            drive_beats(8, 32'h0, -1, 4'h0, stalls, fs);
            begin
                g = 0;
                while (!bus.out_valid_o && g < 50) begin @(posedge clk); #1; g++; end
                bus.out_ready_i = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(posedge clk); #1;
                    if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== {32'h3, 32'h2, 32'h1, 32'h0}) held_bad++;
                end
                bus.out_ready_i = 1'b1;
            end
        join
        wait_done("backpressure");
        idle_cycles(2);
        n_checks++;
        if (held_bad != 0) begin n_fail++; $display("FAIL bp hold: %0d unstable cycles want 0", held_bad); end
        n_checks++;
        if (fs != 7 || stalls != 2) begin n_fail++; $display("FAIL bp in_ready drop: first stall beat %0d stalls %0d want 7 and 2", fs, stalls); end
        n_checks++;
        if (wq_data.size() - wb != 2) begin n_fail++; $display("FAIL bp word count: got %0d want 2", wq_data.size() - wb); end
        n_checks++;
        if (word_d(wb) !== {32'h3, 32'h2, 32'h1, 32'h0} || word_d(wb+1) !== {32'h7, 32'h6, 32'h5, 32'h4}) begin
            n_fail++; $display("FAIL bp order: got %h then %h", word_d(wb), word_d(wb+1));
        end
    endtask

    task automatic test_zero_len();
        int st;
        int i0 = ir_cnt;
        int o0 = ov_cnt;
        int wb = wq_data.size();
        start_burst(16'd0, st);
        wait_done("zero");
        idle_cycles(2);
        n_checks++;
        if (done_cyc - st != 2) begin n_fail++; $display("FAIL zero done latency: got %0d want 2", done_cyc - st); end
        n_checks++;
        if (ir_cnt != i0 || ov_cnt != o0 || wq_data.size() != wb) begin
            n_fail++; $display("FAIL zero activity: in_ready %0d out_valid %0d words %0d want 0", ir_cnt - i0, ov_cnt - o0, wq_data.size() - wb);
        end
    endtask

    task automatic test_clear();
        int st, stalls, fs;
        int wb, d0;
        bus.out_ready_i = 1'b0;
        start_burst(16'd8, st);
        drive_beats(4, 32'h10, -1, 4'h0, stalls, fs);
        n_checks++;
        if (bus.out_valid_o !== 1'b1) begin n_fail++; $display("FAIL clear pre out_valid: got %b want 1", bus.out_valid_o); end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        n_checks++;
        if (bus.out_valid_o !== 1'b0 || bus.out_strb_o !== '0 || bus.ready_start_o !== 1'b1) begin
            n_fail++; $display("FAIL clear state: valid %b strb %h ready_start %b want 0/0000/1", bus.out_valid_o, bus.out_strb_o, bus.ready_start_o);
        end
        bus.out_ready_i = 1'b1;
        wb = wq_data.size();
        d0 = done_cnt;
        start_burst(16'd4, st);
        drive_beats(4, 32'h20, -1, 4'h0, stalls, fs);
        wait_done("clear");
        idle_cycles(2);
        n_checks++;
        if (wq_data.size() - wb != 1 || word_d(wb) !== {32'h23, 32'h22, 32'h21, 32'h20} || word_s(wb) !== 16'hFFFF) begin
            n_fail++; $display("FAIL clear fresh word: count %0d got %h/%h", wq_data.size() - wb, word_d(wb), word_s(wb));
        end
        n_checks++;
        if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL clear done count: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_start_ignored();
        int st, stalls, fs;
        int wb = wq_data.size();
        int d0 = done_cnt;
        start_burst(16'd4, st);
        fork
            drive_beats(4, 32'h40, 1, 4'h3, stalls, fs);
            begin
                @(posedge clk); #1;
                bus.ctrl_start_i = 1'b1;
                bus.ctrl_len_i   = 16'd2;
                @(posedge clk); #1;
                bus.ctrl_start_i = 1'b0;
            end
        join
        wait_done("start_ign");
        idle_cycles(4);
        n_checks++;
        if (wq_data.size() - wb != 1) begin n_fail++; $display("FAIL start_ign word count: got %0d want 1", wq_data.size() - wb); end
        n_checks++;
        if (word_d(wb) !== {32'h43, 32'h42, 32'h41, 32'h40} || word_s(wb) !== 16'hFF3F) begin
            n_fail++; $display("FAIL start_ign word: got %h/%h want 00000043000000420000004100000040/ff3f", word_d(wb), word_s(wb));
        end
        n_checks++;
        if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL start_ign done count: got %0d want 1", done_cnt - d0); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst              = 1'b1;
        clear            = 1'b0;
        bus.ctrl_start_i = 1'b0;
        bus.ctrl_len_i   = '0;
        bus.in_valid_i   = 1'b0;
        bus.in_data_i    = '0;
        bus.in_strb_i    = '0;
        bus.out_ready_i  = 1'b1;
        test_reset();
        test_full_burst();
        test_partial();
        test_backpressure();
        test_zero_len();
        test_clear();
        test_start_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hwpe_stream_packer.md
Name: hwpe_stream_packer

Overview:
- Upstream neighbour of the HWPE TCDM store stage.
- Collects a counted burst of narrow HWPE-stream beats and packs them into full-width words with per-byte strobes.
- Its output feeds the store stage's wide stream input. An engine datapath can therefore emit IN_WIDTH-bit results while stores stay at OUT_WIDTH.
- Driven by a start/length control and reports done and ready_start, in the same style as the source/sink control plane.

Parameters:
IN_WIDTH, 32, width of input beats in bits; multiple of 8.
OUT_WIDTH, 128, width of packed output words in bits; OUT_WIDTH/IN_WIDTH = RATIO, a power of two, 2 or greater.
LEN_WIDTH, 16, width of the beat-count control field.

Ports:
clk_i  input  1  clock.
rst_i  input  1  reset; synchronous, active-high.
clear_i  input  1  synchronous soft clear; same effect as rst_i.
ctrl_start_i  input  1  start request; sampled only in IDLE.
ctrl_len_i  input  LEN_WIDTH  number of input beats in the burst; latched on start.
ready_start_o  output  1  high in IDLE.
done_o  output  1  one-cycle pulse at burst end.
in_valid_i  input  1  input beat valid.
in_ready_o  output  1  input beat ready.
in_data_i  input  IN_WIDTH  input data.
in_strb_i  input  IN_WIDTH/8  input byte strobes.
out_valid_o  output  1  packed word valid.
out_ready_i  input  1  downstream ready.
out_data_o  output  OUT_WIDTH  packed data; lane k = bits [k*IN_WIDTH +: IN_WIDTH].
out_strb_o  output  OUT_WIDTH/8  packed byte strobes.

Behaviour:
- Reset/clear (highest priority, synchronous):
  - State = IDLE; lane index, beat counter and accumulator cleared.
  - out_valid_o=0, out_data_o=0, out_strb_o=0, done_o=0, in_ready_o=0, ready_start_o=1.
  - An in-flight output word is discarded.
- States:
  - IDLE: on ctrl_start_i, latch len. If len==0, go to DRAIN with no beats accepted. Otherwise go to FILL with idx=0, cnt=0.
  - FILL: accept input beats.
  - DRAIN: wait for the final word to leave.
- Accept rule: a beat is accepted when in_valid_i && in_ready_o.
  - "completing" = (idx==RATIO-1) || (cnt==len-1).
  - in_ready_o = (state==FILL) && !(completing && out_valid_o && !out_ready_i).
  - in_ready_o is combinational from state, counters and output handshake; it never depends on in_valid_i.
- Non-completing accept:
  - Accumulator lane idx <= in_data_i and its strobes <= in_strb_i.
  - idx++, cnt++.
- Completing accept:
  - out_data_o <= accumulator merged with the current beat in lane idx; out_strb_o likewise.
  - Lanes never written carry data 0 and strobe 0.
  - out_valid_o <= 1 on the next edge; latency is 1 cycle from the completing accept.
  - Accumulator and idx cleared; cnt++.
  - If cnt==len-1, go to DRAIN.
- Output register:
  - Holds data and strobes stable while out_valid_o && !out_ready_i.
  - Cleared to valid=0 on a handshake unless a new completing accept happens in the same cycle; in that case the new word loads back-to-back.
  - Sustained throughput: 1 input beat per cycle with out_ready_i high.
- DRAIN:
  - When !out_valid_o || out_ready_i, go to IDLE and pulse done_o=1 for exactly one cycle; the pulse is registered and coincides with re-entering IDLE.
- Boundaries:
  - ctrl_start_i outside IDLE is ignored.
  - len is not a multiple of RATIO: the final word is partial, upper lanes have strobe 0.
  - A beat with in_strb_i=0 still occupies its lane and counts.
  - Counters are sized LEN_WIDTH; len up to 2^LEN_WIDTH-1 is supported without wrap.

Test Plan:
- RATIO=4, len=8, beats 0x0..0x7, out_ready_i=1:
  - two words 0x00000003_00000002_00000001_00000000 and 0x7_6_5_4 lanes, strb 0xFFFF each;
  - in_ready_o high 8 consecutive cycles;
  - done_o pulses once, 1 cycle after the second word handshakes.
- len=6: second word lanes 1:0 = beats 5:4, lanes 3:2 = 0, out_strb_o=0x00FF; done_o pulse; ready_start_o back to 1.
- Backpressure: hold out_ready_i=0 for 5 cycles after the first word.
  - in_ready_o drops only on the completing beat of word 2;
  - word 1 data stays stable;
  - both words delivered in order with no loss or duplication.
- len=0 start: no in_ready_o, no out_valid_o; done_o=1 exactly 2 cycles after start.
- clear_i asserted mid-burst with out_valid_o=1: next cycle out_valid_o=0, out_strb_o=0, ready_start_o=1; a fresh len=4 burst yields one correct word.
- ctrl_start_i pulsed in FILL with a different len: ignored; the original burst completes with its latched length; in_strb_i=0x3 on beat 1 gives out_strb_o=0xFF3F.
